// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial add/subtract engine. It computes the same function as the
// WIDTH-bit ripple add/sub datapath, but processes one bit per clock, LSB first.
// Operations are issued and collected through a start/busy/done handshake.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous, active-low reset
//   start  - operation request, sampled in IDLE or DONE
//   a, b   - operands, captured when a start is accepted
//   cin    - carry-in (add) / borrow-in (sub), captured with the operands
//   s_op   - 0 = add, 1 = subtract, captured with the operands
//   busy   - high while bits are being processed
//   done   - one-cycle pulse, result valid
//   s      - result, held until the next accepted start
//   cout   - carry-out (add) / not-borrow (sub)
//   ovf    - signed overflow, present only when SERIAL_ADDSUB_OVF_EN is defined
//
// Configuration macro: SERIAL_ADDSUB_OVF_EN adds the ovf output and its logic.

module serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             s_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               cout_q, cout_d;
   logic               sumBit;
   logic               carryNext;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   // State and datapath registers. Reset clears everything, so a reset in the
   // middle of an operation aborts it with no done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // One full-adder cell. The operand registers shift right every RUN cycle,
   // so bit 0 always holds the bit currently being processed.
   always_comb begin
      sumBit    = a_q[0] ^ b_q[0] ^ carry_q;
      carryNext = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
   end

   // Next-state logic. Subtraction is done as a + ~b + ~borrow, so the
   // operand and the initial carry are inverted at capture time. Result bits
   // enter at the MSB and shift down, so s is right-aligned after WIDTH cycles.
   // cout (and ovf) change only on the last bit, so they stay stable otherwise.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{s_op}};
               carry_d = cin ^ s_op;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            s_d     = {sumBit, s_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = carryNext;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               cout_d  = carryNext;
`ifdef SERIAL_ADDSUB_OVF_EN
               // Carry into the MSB is carry_q here; carry out of it is carryNext.
               ovf_d   = carry_q ^ carryNext;
`endif
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode the state register directly. Result outputs
   // come straight from their registers.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      s    = s_q;
      cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf  = ovf_q;
`endif
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Directed-vector testbench for serial_addsub (WIDTH = 4). Expected values
// are hand-computed constants. Inputs are driven and outputs sampled on the
// falling clock edge, away from the active rising edge.

module tb_serial_addsub;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             s_op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_addsub #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .s_op  (s_op),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Pulse start for one cycle with the given operands; returns on the
   // falling edge right after the accepting rising edge, with start low.
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tcin, input logic top);
      a     = ta;
      b     = tb;
      cin   = tcin;
      s_op  = top;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = ~ta;
      b     = ~tb;
   endtask

   // Wait (bounded) for done, counting falling edges and busy samples.
   task automatic waitDone(output int cycles, output int busyCnt);
      cycles  = 0;
      busyCnt = 0;
      while (!done && cycles < 20) begin
         if (busy) busyCnt++;
         @(negedge clk);
         cycles++;
      end
   endtask

   // Full operation: issue, wait, check latency, busy length, results, and
   // that done drops after one cycle while the result holds.
   task automatic runOp(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tcin, input logic top, input int expS, input int expCout);
      int cyc, bcnt;
      applyStimulus(ta, tb, tcin, top);
      waitDone(cyc, bcnt);
      checkOutput({tag, " latency"}, cyc + 1, WIDTH + 1);
      checkOutput({tag, " busy cycles"}, bcnt, WIDTH);
      checkOutput({tag, " busy in done"}, int'(busy), 0);
      checkOutput({tag, " s"}, int'(s), expS);
      checkOutput({tag, " cout"}, int'(cout), expCout);
      @(negedge clk);
      checkOutput({tag, " done pulse width"}, int'(done), 0);
      checkOutput({tag, " s held"}, int'(s), expS);
   endtask

   initial begin
      int cyc, bcnt, firstDone, secondDone, doneSeen;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      s_op  = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset done", int'(done), 0);
      checkOutput("reset s", int'(s), 0);
      checkOutput("reset cout", int'(cout), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
      checkOutput("reset ovf", int'(ovf), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors.
      runOp("add 1+1", 4'd1, 4'd1, 1'b0, 1'b0, 2, 0);
      runOp("add 15+1", 4'd15, 4'd1, 1'b0, 1'b0, 0, 1);
`ifdef SERIAL_ADDSUB_OVF_EN
      checkOutput("add 15+1 ovf", int'(ovf), 0);
`endif
      runOp("add 6+5+cin", 4'd6, 4'd5, 1'b1, 1'b0, 12, 0);
      runOp("sub 3-5", 4'd3, 4'd5, 1'b0, 1'b1, 14, 0);
      runOp("sub 7-7-1", 4'd7, 4'd7, 1'b1, 1'b1, 15, 0);
      runOp("sub 9-4", 4'd9, 4'd4, 1'b0, 1'b1, 5, 1);
`ifdef SERIAL_ADDSUB_OVF_EN
      runOp("add 7+1", 4'd7, 4'd1, 1'b0, 1'b0, 8, 0);
      checkOutput("add 7+1 ovf", int'(ovf), 1);
      runOp("sub 8-1", 4'd8, 4'd1, 1'b0, 1'b1, 7, 1);
      checkOutput("sub 8-1 ovf", int'(ovf), 1);
`endif

      // A start during RUN must be ignored.
      applyStimulus(4'd10, 4'd3, 1'b0, 1'b1);
      applyStimulus(4'd1, 4'd1, 1'b0, 1'b0);
      waitDone(cyc, bcnt);
      checkOutput("midrun latency", cyc, WIDTH - 1);
      checkOutput("midrun s", int'(s), 7);
      checkOutput("midrun cout", int'(cout), 1);
      @(negedge clk);
      checkOutput("midrun no restart", int'(busy), 0);

      // start held high: a new op accepted in every DONE cycle.
      a     = 4'd3;
      b     = 4'd5;
      cin   = 1'b0;
      s_op  = 1'b1;
      start = 1'b1;
      firstDone  = -1;
      secondDone = -1;
      for (int i = 1; i <= 20 && secondDone < 0; i++) begin
         @(negedge clk);
         if (done) begin
            if (firstDone < 0) begin
               firstDone = i;
               checkOutput("held first s", int'(s), 14);
            end else begin
               secondDone = i;
               checkOutput("held second s", int'(s), 14);
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checkOutput("held first latency", firstDone, WIDTH + 1);
      checkOutput("held done spacing", secondDone - firstDone, WIDTH + 1);
      @(negedge clk);

      // Reset two cycles into RUN aborts the op.
      applyStimulus(4'd12, 4'd2, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort done", int'(done), 0);
      checkOutput("abort s", int'(s), 0);
      checkOutput("abort cout", int'(cout), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) doneSeen++;
      end
      checkOutput("abort no done", doneSeen, 0);

      // Engine still works after the abort.
      runOp("post-abort 9+4", 4'd9, 4'd4, 1'b0, 1'b0, 13, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial add/subtract engine computing the same function as the 4-bit ripple add/sub datapath, one bit per clock, LSB first. It uses a start/busy/done handshake, so a sequencer or bench can issue operations and collect registered results. It sits beside the combinational ripple unit as its area-minimal, clocked counterpart and as a cross-check target for it.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
- s_op  input  1  0 = add, 1 = subtract, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid
- s  output  WIDTH  result, held until the next accepted start
- cout  output  1  carry-out (add) / not-borrow (sub)
- ovf  output  1  signed overflow (only with SERIAL_ADDSUB_OVF_EN)

## Operation
- Effective operand: b_eff = b XOR {WIDTH{s_op}}; initial carry c0 = cin XOR s_op.
- Add: {cout,s} = a + b + cin. Sub: s = a − b − cin mod 2^WIDTH; cout = 1 iff a ≥ b + cin (unsigned).
- States:
  - IDLE: busy=0, done=0. start=1 → capture a, b_eff, c0; clear bit counter; go to RUN.
  - RUN: each cycle, full-add bit i = a[i] ^ b_eff[i] ^ carry; shift result into s register MSB-first (so s is right-aligned after WIDTH shifts); update carry; counter++. After bit WIDTH−1, go to DONE.
  - DONE: done=1 for exactly one cycle; cout = final carry; s final. start=1 → capture and go to RUN (back-to-back); otherwise go to IDLE.
- start in RUN is ignored; operand changes after capture have no effect.
- s and cout are driven only from internal registers. Outputs are stable except during RUN, when the s register shifts; consumers read s and cout only on done or afterwards.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, counter=0.
- start accepted at edge E0 → busy=1 from E0 through edge E0+WIDTH; done=1 in the cycle after edge E0+WIDTH; busy=0 in that same cycle.
- Latency: start to done = WIDTH+1 cycles; throughput: one op per WIDTH+1 cycles with back-to-back starts.
- rst_n asserted mid-RUN aborts the op immediately; all outputs return to reset values and no done is issued.
- start held high continuously: a new op is accepted in every DONE cycle.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: ovf output present; in DONE it is set to carry_into_MSB XOR carry_out_of_MSB (two's-complement overflow) and held with s.
- Undefined: ovf port and its logic are omitted; all other behaviour is identical.

## Test plan
- Reset, then a=1, b=1, cin=0, s_op=0, start one cycle → done 5 cycles later, s=2, cout=0; busy high exactly 4 cycles.
- a=15, b=1, cin=0, add → s=0, cout=1; with OVF_EN, ovf=0.
- a=3, b=5, cin=0, s_op=1 → s=14, cout=0; a=7, b=7, cin=1, sub → s=15, cout=0; a=9, b=4, cin=0, sub → s=5, cout=1.
- With OVF_EN: a=7, b=1, add → s=8, ovf=1; a=8, b=1, sub → s=7, ovf=1.
- Pulse start again mid-RUN with different operands → ignored; first result is unchanged. Hold start high → consecutive dones 5 cycles apart.
- Assert rst_n low 2 cycles into RUN → busy, done, s, and cout are 0 immediately; no done pulse until a new start.
